// File: rtl/ram_nr_mw_init_core.sv
// ram_nr_mw_init_core: multi-port RAM, N read / M write ports, one clock.
// The array cannot be cleared by the async reset, so after reset an init
// sweep writes INIT_VAL to every word. The read latency (0/1/2) and the
// write-to-read bypass can be configured.
// Ports:
//   clk, a_rst_n                  clock and async active-low reset
//   wr_en/wr_add/wr_data [M]      write ports; the highest index wins on a clash
//   rd_en/rd_add [N]              read requests
//   rd_data/rd_data_vld [N]       read results
//   init_done                     high once the sweep has finished
//   wr_collision                  pulse: enabled write ports hit the same address
//   wr_drop                       pulse: a request arrived during the sweep
module ram_nr_mw_init_core #(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH      = 64,
    parameter int               RD_PORT_NB = 2,
    parameter int               WR_PORT_NB = 2,
    parameter int               RD_LATENCY = 1,
    parameter int               BYPASS     = 1,
    parameter logic [WIDTH-1:0] INIT_VAL   = '0,
    localparam int              ADD_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                                 clk,
    input  logic                                 a_rst_n,
    input  logic [WR_PORT_NB-1:0]                wr_en,
    input  logic [WR_PORT_NB-1:0][ADD_W-1:0]     wr_add,
    input  logic [WR_PORT_NB-1:0][WIDTH-1:0]     wr_data,
    input  logic [RD_PORT_NB-1:0]                rd_en,
    input  logic [RD_PORT_NB-1:0][ADD_W-1:0]     rd_add,
    output logic [RD_PORT_NB-1:0][WIDTH-1:0]     rd_data,
    output logic [RD_PORT_NB-1:0]                rd_data_vld,
    output logic                                 init_done,
    output logic                                 wr_collision,
    output logic                                 wr_drop
);

    localparam logic [ADD_W:0]   LP_DEPTH = (ADD_W + 1)'(DEPTH);
    localparam logic [ADD_W-1:0] LP_LAST  = ADD_W'(DEPTH - 1);
    // Bypass only makes sense when the read data is registered.
    localparam bit               LP_BYP   = (BYPASS != 0) && (RD_LATENCY >= 1);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                              r_state;
    logic [ADD_W-1:0]                    r_init_add;
    logic                                r_init_done;
    logic                                r_wr_coll;
    logic                                r_wr_drop;
    logic [WIDTH-1:0]                    r_ram [DEPTH];

    logic                                w_ready;
    logic                                w_coll;
    logic [WR_PORT_NB-1:0]               w_wr_ok;
    logic [RD_PORT_NB-1:0]               w_rd_ok;
    logic [RD_PORT_NB-1:0]               w_vld;
    logic [RD_PORT_NB-1:0][WIDTH-1:0]    w_rd_old;
    logic [RD_PORT_NB-1:0][WIDTH-1:0]    w_rd_new;
    logic [RD_PORT_NB-1:0][WIDTH-1:0]    w_rd_sel;

    assign w_ready      = (r_state == ST_READY);
    assign init_done    = r_init_done;
    assign wr_collision = r_wr_coll;
    assign wr_drop      = r_wr_drop;

    // Init FSM and status pulses.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_state     <= ST_INIT;
            r_init_add  <= '0;
            r_init_done <= 1'b0;
            r_wr_coll   <= 1'b0;
            r_wr_drop   <= 1'b0;
        end else begin
            r_wr_coll <= w_coll;
            r_wr_drop <= !w_ready && ((|wr_en) || (|rd_en));
            unique case (r_state)
                ST_INIT: begin
                    if (r_init_add == LP_LAST) begin
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end else begin
                        r_init_add <= r_init_add + ADD_W'(1);
                    end
                end
                ST_READY: begin
                    r_state <= ST_READY;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    always_comb begin
        for (int j = 0; j < WR_PORT_NB; j++) begin
            w_wr_ok[j] = wr_en[j] && ({1'b0, wr_add[j]} < LP_DEPTH);
        end
    end

    // Any pair of enabled ports on the same address is a collision.
    always_comb begin
        w_coll = 1'b0;
        for (int j = 0; j < WR_PORT_NB; j++) begin
            for (int k = j + 1; k < WR_PORT_NB; k++) begin
                if (wr_en[j] && wr_en[k] && (wr_add[j] == wr_add[k])) begin
                    w_coll = 1'b1;
                end
            end
        end
        w_coll = w_coll && w_ready;
    end

    // Storage: no reset. Ports are applied in ascending order so the
    // highest-indexed port lands last and wins.
    always_ff @(posedge clk) begin
        if (!w_ready) begin
            r_ram[r_init_add] <= INIT_VAL;
        end else begin
            for (int j = 0; j < WR_PORT_NB; j++) begin
                if (w_wr_ok[j]) begin
                    r_ram[wr_add[j]] <= wr_data[j];
                end
            end
        end
    end

    // Read lookup: the old word, plus the word as it will be after this
    // cycle's writes (used when bypass is enabled).
    always_comb begin
        for (int i = 0; i < RD_PORT_NB; i++) begin
            w_rd_ok[i]  = ({1'b0, rd_add[i]} < LP_DEPTH);
            w_vld[i]    = rd_en[i] && r_init_done;
            w_rd_old[i] = w_rd_ok[i] ? r_ram[rd_add[i]] : INIT_VAL;
            w_rd_new[i] = w_rd_old[i];
            for (int j = 0; j < WR_PORT_NB; j++) begin
                if (w_ready && w_wr_ok[j] && (wr_add[j] == rd_add[i])) begin
                    w_rd_new[i] = wr_data[j];
                end
            end
            w_rd_sel[i] = LP_BYP ? w_rd_new[i] : w_rd_old[i];
        end
    end

    generate
        if (RD_LATENCY == 0) begin : g_lat0
            assign rd_data     = w_rd_old;
            assign rd_data_vld = w_vld;
        end else begin : g_latn
            logic [RD_PORT_NB-1:0][WIDTH-1:0] r_d1;
            logic [RD_PORT_NB-1:0]            r_v1;

            always_ff @(posedge clk or negedge a_rst_n) begin
                if (!a_rst_n) begin
                    r_d1 <= '0;
                    r_v1 <= '0;
                end else begin
                    r_v1 <= w_vld;
                    for (int i = 0; i < RD_PORT_NB; i++) begin
                        if (w_vld[i]) begin
                            r_d1[i] <= w_rd_sel[i];
                        end
                    end
                end
            end

            if (RD_LATENCY == 1) begin : g_lat1
                assign rd_data     = r_d1;
                assign rd_data_vld = r_v1;
            end else begin : g_lat2
                logic [RD_PORT_NB-1:0][WIDTH-1:0] r_d2;
                logic [RD_PORT_NB-1:0]            r_v2;

                always_ff @(posedge clk or negedge a_rst_n) begin
                    if (!a_rst_n) begin
                        r_d2 <= '0;
                        r_v2 <= '0;
                    end else begin
                        r_v2 <= r_v1;
                        for (int i = 0; i < RD_PORT_NB; i++) begin
                            if (r_v1[i]) begin
                                r_d2[i] <= r_d1[i];
                            end
                        end
                    end
                end

                assign rd_data     = r_d2;
                assign rd_data_vld = r_v2;
            end
        end
    endgenerate

endmodule

// File: tb/tb_ram_nr_mw_init_core.sv
// Bench for ram_nr_mw_init_core: five configurations share one stimulus
// stream and are checked against an array model of the memory.
module tb_ram_nr_mw_init_core;

    localparam logic [31:0] IV = 32'hA5A5A5A5;

    logic clk = 1'b0;
    logic a_rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       wr_en, rd_en;
    logic [1:0][5:0]  wr_add, rd_add;
    logic [1:0][31:0] wr_data;

    // m: lat1 bypass, z: lat0, t: lat2 bypass, n: lat1 no bypass, s: depth 48
    logic [1:0][31:0] d_m, d_z, d_t, d_n, d_s;
    logic [1:0]       v_m, v_z, v_t, v_n, v_s;
    logic [4:0]       done, coll, drop;

    ram_nr_mw_init_core #(.WIDTH(32), .DEPTH(64), .RD_PORT_NB(2), .WR_PORT_NB(2),
        .RD_LATENCY(1), .BYPASS(1), .INIT_VAL(IV)) u_m (
        .clk(clk), .a_rst_n(a_rst_n), .wr_en(wr_en), .wr_add(wr_add),
        .wr_data(wr_data), .rd_en(rd_en), .rd_add(rd_add), .rd_data(d_m),
        .rd_data_vld(v_m), .init_done(done[0]), .wr_collision(coll[0]),
        .wr_drop(drop[0]));

    ram_nr_mw_init_core #(.WIDTH(32), .DEPTH(64), .RD_PORT_NB(2), .WR_PORT_NB(2),
        .RD_LATENCY(0), .BYPASS(1), .INIT_VAL(IV)) u_z (
        .clk(clk), .a_rst_n(a_rst_n), .wr_en(wr_en), .wr_add(wr_add),
        .wr_data(wr_data), .rd_en(rd_en), .rd_add(rd_add), .rd_data(d_z),
        .rd_data_vld(v_z), .init_done(done[1]), .wr_collision(coll[1]),
        .wr_drop(drop[1]));

    ram_nr_mw_init_core #(.WIDTH(32), .DEPTH(64), .RD_PORT_NB(2), .WR_PORT_NB(2),
        .RD_LATENCY(2), .BYPASS(1), .INIT_VAL(IV)) u_t (
        .clk(clk), .a_rst_n(a_rst_n), .wr_en(wr_en), .wr_add(wr_add),
        .wr_data(wr_data), .rd_en(rd_en), .rd_add(rd_add), .rd_data(d_t),
        .rd_data_vld(v_t), .init_done(done[2]), .wr_collision(coll[2]),
        .wr_drop(drop[2]));

    ram_nr_mw_init_core #(.WIDTH(32), .DEPTH(64), .RD_PORT_NB(2), .WR_PORT_NB(2),
        .RD_LATENCY(1), .BYPASS(0), .INIT_VAL(IV)) u_n (
        .clk(clk), .a_rst_n(a_rst_n), .wr_en(wr_en), .wr_add(wr_add),
        .wr_data(wr_data), .rd_en(rd_en), .rd_add(rd_add), .rd_data(d_n),
        .rd_data_vld(v_n), .init_done(done[3]), .wr_collision(coll[3]),
        .wr_drop(drop[3]));

    ram_nr_mw_init_core #(.WIDTH(32), .DEPTH(48), .RD_PORT_NB(2), .WR_PORT_NB(2),
        .RD_LATENCY(1), .BYPASS(1), .INIT_VAL(IV)) u_s (
        .clk(clk), .a_rst_n(a_rst_n), .wr_en(wr_en), .wr_add(wr_add),
        .wr_data(wr_data), .rd_en(rd_en), .rd_add(rd_add), .rd_data(d_s),
        .rd_data_vld(v_s), .init_done(done[4]), .wr_collision(coll[4]),
        .wr_drop(drop[4]));

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mem64 [64];
    logic [31:0] mem48 [48];

    typedef struct packed {
        logic [1:0]       vld;
        logic [1:0][31:0] byp;
        logic [1:0][31:0] old;
        logic [1:0][31:0] s48;
        logic             coll;
    } exp_t;

    exp_t cur, d1, d2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 64; k++) mem64[k] = IV;
        for (int k = 0; k < 48; k++) mem48[k] = IV;
        d1 = '0;
        d2 = '0;
    endtask

    // Release happened at the current negedge; c counts edges since release.
    task automatic do_sweep(input bit drive);
        for (int c = 0; c < 64; c++) begin
            wr_en   = (drive && c < 48) ? 2'b11 : 2'b00;
            rd_en   = wr_en;
            wr_add  = {6'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
            rd_add  = {6'($urandom), 6'($urandom)};
            wr_data = {$urandom, $urandom};
            #1;
            chk($sformatf("sweep_done c%0d", c), 32'(done),
                (c >= 48) ? 32'h10 : 32'h0);
            chk($sformatf("sweep_drop c%0d", c), 32'(drop),
                (drive && c >= 1 && c <= 48) ? 32'h1F : 32'h0);
            chk($sformatf("sweep_vld c%0d", c),
                32'({v_m, v_z, v_t, v_n, v_s}), 32'h0);
            chk($sformatf("sweep_coll c%0d", c), 32'(coll), 32'h0);
            @(negedge clk);
        end
        wr_en = '0;
        rd_en = '0;
        #1;
        chk("sweep_done_end", 32'(done), 32'h1F);
        chk("sweep_drop_end", 32'(drop), 32'h0);
        model_reset();
    endtask

    task automatic step(input logic [1:0] we, input logic [5:0] wa0, input logic [5:0] wa1,
                        input logic [31:0] wd0, input logic [31:0] wd1,
                        input logic [1:0] re, input logic [5:0] ra0, input logic [5:0] ra1);
        logic [5:0] a;
        wr_en   = we;
        wr_add  = {wa1, wa0};
        wr_data = {wd1, wd0};
        rd_en   = re;
        rd_add  = {ra1, ra0};
        cur      = '0;
        cur.vld  = re;
        cur.coll = we[0] && we[1] && (wa0 == wa1);
        for (int i = 0; i < 2; i++) begin
            a = rd_add[i];
            cur.old[i] = mem64[a];
            cur.byp[i] = mem64[a];
            cur.s48[i] = (a < 48) ? mem48[a] : IV;
            for (int j = 0; j < 2; j++) begin
                if (we[j] && wr_add[j] == a) begin
                    cur.byp[i] = wr_data[j];
                    if (a < 48) cur.s48[i] = wr_data[j];
                end
            end
        end
        #1;
        chk("vld_lat0", 32'(v_z), 32'(cur.vld));
        chk("vld_lat1", 32'(v_m), 32'(d1.vld));
        chk("vld_nobyp", 32'(v_n), 32'(d1.vld));
        chk("vld_d48", 32'(v_s), 32'(d1.vld));
        chk("vld_lat2", 32'(v_t), 32'(d2.vld));
        for (int i = 0; i < 2; i++) begin
            if (cur.vld[i]) chk($sformatf("dat_lat0 p%0d", i), d_z[i], cur.old[i]);
            if (d1.vld[i]) begin
                chk($sformatf("dat_lat1 p%0d", i), d_m[i], d1.byp[i]);
                chk($sformatf("dat_nobyp p%0d", i), d_n[i], d1.old[i]);
                chk($sformatf("dat_d48 p%0d", i), d_s[i], d1.s48[i]);
            end
            if (d2.vld[i]) chk($sformatf("dat_lat2 p%0d", i), d_t[i], d2.byp[i]);
        end
        chk("wr_collision", 32'(coll), d1.coll ? 32'h1F : 32'h0);
        chk("wr_drop", 32'(drop), 32'h0);
        chk("init_done", 32'(done), 32'h1F);
        for (int j = 0; j < 2; j++) begin
            if (we[j]) begin
                mem64[wr_add[j]] = wr_data[j];
                if (wr_add[j] < 48) mem48[wr_add[j]] = wr_data[j];
            end
        end
        d2 = d1;
        d1 = cur;
        @(negedge clk);
    endtask

    task automatic idle();
        step(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 2'b00, 6'd0, 6'd0);
    endtask

    function automatic logic [5:0] rnd_add();
        return ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 3))
                                           : 6'($urandom_range(0, 63));
    endfunction

    initial begin
        wr_en = '0; rd_en = '0; wr_add = '0; rd_add = '0; wr_data = '0;
        cur = '0; d1 = '0; d2 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_coll", 32'(coll), 32'h0);
        chk("rst_drop", 32'(drop), 32'h0);
        chk("rst_vld", 32'({v_m, v_z, v_t, v_n, v_s}), 32'h0);
        chk("rst_dat_lat1", d_m[0] | d_m[1] | d_n[0] | d_s[1], 32'h0);
        chk("rst_dat_lat2", d_t[0] | d_t[1], 32'h0);

        @(negedge clk);
        a_rst_n = 1'b1;
        do_sweep(1'b1);

        for (int k = 0; k < 32; k++)
            step(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 2'b11, 6'(2 * k), 6'(2 * k + 1));
        idle(); idle();

        step(2'b01, 6'd5, 6'd0, 32'h12345678, 32'd0, 2'b00, 6'd0, 6'd0);
        idle();
        step(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 2'b10, 6'd0, 6'd5);
        idle(); idle(); idle();

        step(2'b11, 6'd7, 6'd7, 32'h1111, 32'h2222, 2'b00, 6'd0, 6'd0);
        idle(); idle();
        step(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 2'b01, 6'd7, 6'd0);
        idle(); idle();

        step(2'b01, 6'd3, 6'd0, 32'hAAAA, 32'd0, 2'b00, 6'd0, 6'd0);
        idle();
        step(2'b01, 6'd3, 6'd0, 32'hBBBB, 32'd0, 2'b01, 6'd3, 6'd0);
        idle();
        step(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 2'b11, 6'd3, 6'd3);
        idle(); idle();

        step(2'b10, 6'd0, 6'd50, 32'd0, 32'hDEADBEEF, 2'b00, 6'd0, 6'd0);
        idle();
        step(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 2'b11, 6'd50, 6'd2);
        idle(); idle();

        repeat (300)
            step(2'($urandom), rnd_add(), rnd_add(), $urandom, $urandom,
                 2'($urandom), rnd_add(), rnd_add());
        idle(); idle();

        step(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 2'b01, 6'd9, 6'd0);
        idle();
        #1;
        chk("inflight_lat2_vld", 32'(v_t), 32'(d2.vld));
        a_rst_n = 1'b0;
        #1;
        chk("midrst_vld", 32'({v_m, v_z, v_t, v_n, v_s}), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        repeat (2) @(negedge clk);
        a_rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("sweep30_done", 32'(done), 32'h0);
        a_rst_n = 1'b0;
        #1;
        chk("sweep30_rst_done", 32'(done), 32'h0);
        @(negedge clk);
        a_rst_n = 1'b1;
        do_sweep(1'b0);

        step(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 2'b11, 6'd40, 6'd7);
        step(2'b00, 6'd0, 6'd0, 32'd0, 32'd0, 2'b11, 6'd3, 6'd50);
        idle(); idle();
        chk("after_rst_mem40", mem64[40], IV);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
